// File: rtl/frame_sync_deserializer_pkg.sv
// Shared definitions for the frame-sync deserializer: FSM state encoding and
// the default frame sync pattern.
package frame_sync_deserializer_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'b0111_1110;

endpackage

// File: rtl/frame_sync_deserializer.sv
// Serial frame-sync deserializer: hunts for a sync word, confirms it one slot
// later, then emits payload bytes while flywheeling over isolated sync misses.
module frame_sync_deserializer
    import frame_sync_deserializer_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter int         PAYLOAD_BYTES = 2,
    parameter int         MISS_LIMIT    = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output state_e     state_dbg
);

    localparam int               SLOT_BITS   = 8 * (PAYLOAD_BYTES + 1);
    localparam int               CNT_W       = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] PAYLOAD_END = CNT_W'(8 * PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] FIRST_BYTE  = CNT_W'(7);
    localparam logic [1:0]       MISS_MAX    = 2'(MISS_LIMIT);

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       fill_q,  fill_d;
    logic [1:0]       miss_q,  miss_d;
    logic [7:0]       data_q,  data_d;
    logic             dv_q,    dv_d;
    logic             fs_q,    fs_d;
    logic             err_q,   err_d;
    logic             slot_end;
    logic             byte_end;

    assign slot_end = (cnt_q == SYNC_LAST);
    assign byte_end = (cnt_q[2:0] == 3'd7) && (cnt_q < PAYLOAD_END);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        miss_d  = miss_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
        err_d   = 1'b0;
        if (bit_valid) begin
            shift_d = {shift_q[6:0], bit_in};
            case (state_q)
                ST_HUNT: begin
                    // fill_q == 7 means the current bit is the 8th since the search began
                    if (fill_q >= 4'd7 && shift_d == SYNC_WORD) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                        fill_d  = '0;
                    end else if (fill_q != 4'd8) begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                ST_CHECK, ST_LOCK: begin
                    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
                    if (state_q == ST_LOCK && byte_end) begin
                        data_d = shift_d;
                        dv_d   = 1'b1;
                        fs_d   = (cnt_q == FIRST_BYTE);
                    end
                    if (slot_end) begin
                        if (shift_d == SYNC_WORD) begin
                            state_d = ST_LOCK;
                            miss_d  = '0;
                        end else begin
                            err_d = 1'b1;
                            if (state_q == ST_CHECK || (miss_q + 2'd1) == MISS_MAX) begin
                                state_d = ST_HUNT;
                                miss_d  = '0;
                                fill_d  = '0;
                            end else begin
                                miss_d = miss_q + 2'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= ST_HUNT;
            shift_q <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            miss_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            miss_q  <= miss_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign frame_start = fs_q;
    assign sync_err    = err_q;
    assign locked      = (state_q == ST_LOCK);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_sync_deserializer.sv
// Directed bench for frame_sync_deserializer: expected payload bytes are queued
// as they are sent and matched against each data_valid strobe.
module tb_frame_sync_deserializer;
    import frame_sync_deserializer_pkg::*;

    logic       sysclk;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    state_e     state_dbg;

    logic [8:0] exp_q[$];
    logic [8:0] exp_item;
    logic       last_bv;
    int         pass_cnt;
    int         total_cnt;
    int         fail_cnt;
    int         err_seen;

    frame_sync_deserializer dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .state_dbg   (state_dbg)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One valid bit every 4th cycle; bit_in is scrambled while not valid.
    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge sysclk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
        repeat (3) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic expect_byte(input logic fs, input logic [7:0] b);
        exp_q.push_back({fs, b});
    endtask

    always @(negedge sysclk) begin
        if (data_valid === 1'b1) begin
            check("dv_latency", 32'(last_bv), 32'd1);
            if (exp_q.size() == 0) begin
                check("dv_unexpected", 32'(data_valid), 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check("byte_fs", 32'({frame_start, data_out}), 32'(exp_item));
            end
        end else if (frame_start === 1'b1) begin
            check("fs_without_dv", 32'(frame_start), 32'd0);
        end
        if (sync_err === 1'b1) err_seen++;
        last_bv = bit_valid;
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        fail_cnt  = 0;
        err_seen  = 0;
        last_bv   = 1'b0;
        reset     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;

        // Reset held for 8 cycles, released idle
        repeat (8) @(posedge sysclk);
        #1;
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_HUNT));

        // Acquisition: first frame confirms, second frame delivers payload
        send_byte(8'h7E);
        check("check_state", 32'(state_dbg), 32'(ST_CHECK));
        send_byte(8'h69);
        send_byte(8'hC3);
        check("check_not_locked", 32'(locked), 32'd0);
        send_byte(8'h7E);
        check("lock_acquired", 32'(locked), 32'd1);
        expect_byte(1'b1, 8'h69);
        expect_byte(1'b0, 8'hC3);
        send_byte(8'h69);
        send_byte(8'hC3);
        send_byte(8'h7E);
        check("acq_queue_drained", 32'(exp_q.size()), 32'd0);
        check("acq_no_sync_err", 32'(err_seen), 32'd0);

        // Single corrupted sync: flywheel keeps lock and slot timing
        expect_byte(1'b1, 8'h12);
        expect_byte(1'b0, 8'h34);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h7F);
        check("fly_one_err", 32'(err_seen), 32'd1);
        check("fly_still_locked", 32'(locked), 32'd1);
        expect_byte(1'b1, 8'hEF);
        expect_byte(1'b0, 8'hAB);
        send_byte(8'hEF);
        send_byte(8'hAB);
        send_byte(8'h7E);
        check("fly_queue_drained", 32'(exp_q.size()), 32'd0);
        check("fly_locked_after", 32'(locked), 32'd1);

        // Two consecutive corrupted syncs drop lock
        expect_byte(1'b1, 8'h55);
        expect_byte(1'b0, 8'hAA);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h7F);
        check("miss1_locked", 32'(locked), 32'd1);
        expect_byte(1'b1, 8'h01);
        expect_byte(1'b0, 8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        check("miss2_errs", 32'(err_seen), 32'd3);
        check("miss2_unlocked", 32'(locked), 32'd0);
        check("miss2_state", 32'(state_dbg), 32'(ST_HUNT));

        // Payload 7E seen in HUNT is a false sync rejected one slot later
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h7E);
        check("false_check_state", 32'(state_dbg), 32'(ST_CHECK));
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h3C);
        check("false_errs", 32'(err_seen), 32'd4);
        check("false_back_hunt", 32'(state_dbg), 32'(ST_HUNT));
        check("false_not_locked", 32'(locked), 32'd0);
        send_byte(8'h7E);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'h7E);
        check("reacq_locked", 32'(locked), 32'd1);
        expect_byte(1'b1, 8'hC4);
        expect_byte(1'b0, 8'hD5);
        send_byte(8'hC4);
        send_byte(8'hD5);
        send_byte(8'h7E);
        check("reacq_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-payload while locked
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b0;
        @(posedge sysclk);
        #1;
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'h00);
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'(ST_HUNT));
        reset = 1'b1;
        @(posedge sysclk);
        #1;

        // Seven bits leave 7E in the shift register, but the fill count is short
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("fill7_no_sync", 32'(state_dbg), 32'(ST_HUNT));
        send_bit(1'b0);
        send_byte(8'h7E);
        check("post_rst_check", 32'(state_dbg), 32'(ST_CHECK));
        send_byte(8'h9F);
        send_byte(8'h3E);
        send_byte(8'h7E);
        check("post_rst_locked", 32'(locked), 32'd1);
        expect_byte(1'b1, 8'h9F);
        expect_byte(1'b0, 8'h3E);
        send_byte(8'h9F);
        send_byte(8'h3E);
        send_byte(8'h7E);
        repeat (4) @(posedge sysclk);
        #1;
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_errs", 32'(err_seen), 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
